// File: rtl/cpu_bp_pkg.sv
// Types and constants shared between the IF-stage branch predictor and the
// EXE-stage branch resolver.
package cpu_bp_pkg;

  // Branch/jump operation decoded in ID and carried into EXE.
  typedef enum logic [3:0] {
    BR_NONE   = 4'd0,
    BR_BEQ    = 4'd1,
    BR_BNE    = 4'd2,
    BR_BGEZ   = 4'd3,
    BR_BGTZ   = 4'd4,
    BR_BLEZ   = 4'd5,
    BR_BLTZ   = 4'd6,
    BR_J      = 4'd7,
    BR_JAL    = 4'd8,
    BR_JR     = 4'd9,
    BR_JALR   = 4'd10,
    BR_BGEZAL = 4'd11,
    BR_BLTZAL = 4'd12
  } BrOp_t;

  // Branch class used by the BHT/RAS.
  typedef logic [2:0] BType_t;
  localparam BType_t BIsNone = 3'd0;
  localparam BType_t BIsCall = 3'd1;
  localparam BType_t BIsRetn = 3'd2;
  localparam BType_t BIsBran = 3'd3;
  localparam BType_t BIsJump = 3'd4;

  // Two-bit saturating predictor counter states.
  typedef logic [1:0] BCount_t;
  localparam BCount_t T   = 2'b11;
  localparam BCount_t WT  = 2'b10;
  localparam BCount_t WNT = 2'b01;
  localparam BCount_t NT  = 2'b00;

  // Prediction made in IF and carried down the pipe.
  typedef struct packed {
    logic        Valid;
    logic        Hit;
    BType_t      Type;
    logic        IsTaken;
    logic [31:0] Target;
    BCount_t     Count;
  } PResult;

  // Resolved outcome sent back to train the predictor.
  typedef struct packed {
    logic        Valid;
    logic [31:0] PC;
    logic [31:0] Target;
    BType_t      Type;
    logic        IsTaken;
    logic        Hit;
    BCount_t     Count;
  } BResult;

endpackage

// File: rtl/branch_resolver_if.sv
// EXE-stage branch bus: instruction/prediction in, training record and
// front-end redirect out.
interface branch_resolver_if;
  import cpu_bp_pkg::*;

  logic        EXE_Wr;
  logic        EXE_Valid;
  logic        EXE_Flush;
  logic [31:0] EXE_PC;
  BrOp_t       EXE_BrOp;
  logic [31:0] EXE_RsData;
  logic [31:0] EXE_RtData;
  logic [15:0] EXE_Imm16;
  logic [25:0] EXE_Instr26;
  PResult      EXE_PResult;
  logic        ID_Valid;
  BResult      EXE_BResult;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic        IF_Flush;

  // Pipeline side: drives the EXE instruction, consumes redirect/training.
  modport master (
    output EXE_Wr, EXE_Valid, EXE_Flush, EXE_PC, EXE_BrOp, EXE_RsData,
           EXE_RtData, EXE_Imm16, EXE_Instr26, EXE_PResult, ID_Valid,
    input  EXE_BResult, Redirect_Valid, Redirect_PC, IF_Flush
  );

  // Resolver side.
  modport slave (
    input  EXE_Wr, EXE_Valid, EXE_Flush, EXE_PC, EXE_BrOp, EXE_RsData,
           EXE_RtData, EXE_Imm16, EXE_Instr26, EXE_PResult, ID_Valid,
    output EXE_BResult, Redirect_Valid, Redirect_PC, IF_Flush
  );

endinterface

// File: rtl/br_cond_unit.sv
// Combinational branch evaluation: actual direction, target address and
// predictor class for the instruction in EXE.
module br_cond_unit
  import cpu_bp_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  BrOp_t           br_op,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] rs_data,
  input  logic [PC_W-1:0] rt_data,
  input  logic [15:0]     imm16,
  input  logic [25:0]     instr26,
  output logic            taken,
  output logic [PC_W-1:0] target,
  output BType_t          br_type
);

  localparam logic signed [PC_W-1:0] ZERO_S = '0;

  logic signed [PC_W-1:0] rs_s;
  logic [PC_W-1:0]        pc_plus4;
  logic [PC_W-1:0]        br_off;

  assign rs_s     = rs_data;
  assign pc_plus4 = pc + PC_W'(4);
  // Word offset, sign-extended from 18 bits after the <<2.
  assign br_off   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};

  // Decode direction, target and class; all sums wrap modulo 2^PC_W.
  always_comb begin
    taken   = 1'b0;
    target  = pc_plus4 + br_off;
    br_type = BIsBran;
    case (br_op)
      BR_BEQ:               taken = (rs_data == rt_data);
      BR_BNE:               taken = (rs_data != rt_data);
      BR_BGEZ:              taken = (rs_s >= ZERO_S);
      BR_BGTZ:              taken = (rs_s >  ZERO_S);
      BR_BLEZ:              taken = (rs_s <= ZERO_S);
      BR_BLTZ:              taken = (rs_s <  ZERO_S);
      BR_BGEZAL: begin
        taken   = (rs_s >= ZERO_S);
        br_type = BIsCall;
      end
      BR_BLTZAL: begin
        taken   = (rs_s <  ZERO_S);
        br_type = BIsCall;
      end
      BR_J: begin
        taken   = 1'b1;
        target  = {pc_plus4[PC_W-1:28], instr26, 2'b00};
        br_type = BIsJump;
      end
      BR_JAL: begin
        taken   = 1'b1;
        target  = {pc_plus4[PC_W-1:28], instr26, 2'b00};
        br_type = BIsCall;
      end
      // JR only ever reaches EXE as a return; other JR forms are JALR/J.
      BR_JR: begin
        taken   = 1'b1;
        target  = rs_data;
        br_type = BIsRetn;
      end
      BR_JALR: begin
        taken   = 1'b1;
        target  = rs_data;
        br_type = BIsCall;
      end
      default: br_type = BIsNone;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// EXE-stage branch resolver: checks the carried prediction, emits the BHT/RAS
// training record, redirects the front end on a mispredict once the delay
// slot is safely in ID, and counts branch / mispredict events.
module branch_resolver
  import cpu_bp_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_resolver_if.slave   bus,
  output logic [CNT_W-1:0]   Br_Cnt,
  output logic [CNT_W-1:0]   Mis_Cnt
);

  typedef enum logic {ST_IDLE, ST_WAIT_DS} state_t;

  state_t          state_q, state_d;
  logic            redir_vld_q, redir_vld_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  BResult          bres_q, bres_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic            taken;
  logic [PC_W-1:0] target;
  BType_t          br_type;
  logic            r_evt;
  logic            mispred;
  logic [PC_W-1:0] correct_pc;

  br_cond_unit #(.PC_W(PC_W)) u_cond (
    .br_op   (bus.EXE_BrOp),
    .pc      (bus.EXE_PC),
    .rs_data (bus.EXE_RsData),
    .rt_data (bus.EXE_RtData),
    .imm16   (bus.EXE_Imm16),
    .instr26 (bus.EXE_Instr26),
    .taken   (taken),
    .target  (target),
    .br_type (br_type)
  );

  // Resolve only on the advancing edge so a stalled branch is seen once.
  assign r_evt = bus.EXE_Wr & bus.EXE_Valid & (bus.EXE_BrOp != BR_NONE) & ~bus.EXE_Flush;

  assign mispred = taken
                 ? (~bus.EXE_PResult.Valid | ~bus.EXE_PResult.IsTaken |
                    (bus.EXE_PResult.Target != target))
                 : (bus.EXE_PResult.Valid & bus.EXE_PResult.IsTaken);

  // Not-taken resumes after the delay slot.
  assign correct_pc = taken ? target : bus.EXE_PC + PC_W'(8);

  // Next-state, redirect, training record and counter updates.
  always_comb begin
    state_d     = state_q;
    redir_vld_d = 1'b0;
    redir_pc_d  = redir_pc_q;
    pend_pc_d   = pend_pc_q;
    bres_d      = bres_q;
    bres_d.Valid = 1'b0;
    br_cnt_d    = br_cnt_q + CNT_W'(r_evt);
    mis_cnt_d   = mis_cnt_q + CNT_W'(r_evt & mispred);

    if (r_evt) begin
      bres_d = BResult'{Valid: 1'b1, PC: bus.EXE_PC, Target: target, Type: br_type,
                        IsTaken: taken, Hit: bus.EXE_PResult.Hit,
                        Count: bus.EXE_PResult.Count};
    end

    if (bus.EXE_Flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (r_evt && mispred) begin
            if (bus.ID_Valid) begin
              redir_vld_d = 1'b1;
              redir_pc_d  = correct_pc;
            end else begin
              state_d   = ST_WAIT_DS;
              pend_pc_d = correct_pc;
            end
          end
        end
        // Hold the corrected PC until the delay slot has reached ID.
        ST_WAIT_DS: begin
          if (bus.ID_Valid) begin
            redir_vld_d = 1'b1;
            redir_pc_d  = pend_pc_q;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, output and counter registers; reset also drops any pending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      pend_pc_q   <= '0;
      bres_q      <= '0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
      pend_pc_q   <= pend_pc_d;
      bres_q      <= bres_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign bus.EXE_BResult    = bres_q;
  assign bus.Redirect_Valid = redir_vld_q;
  assign bus.IF_Flush       = redir_vld_q;
  assign bus.Redirect_PC    = redir_pc_q;
  assign Br_Cnt             = br_cnt_q;
  assign Mis_Cnt            = mis_cnt_q;

  // A branch in the delay slot of a pending mispredict is illegal code.
  a_no_branch_in_ds: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ST_WAIT_DS) |-> !r_evt);

endmodule

// File: tb/tb_branch_resolver.sv
// Scenario bench for branch_resolver: expected training records and redirect
// PCs are queued as each branch is driven and checked when they appear.
module tb_branch_resolver;
  import cpu_bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] br_cnt, mis_cnt;

  branch_resolver_if bus();

  branch_resolver #(.PC_W(32), .CNT_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .Br_Cnt  (br_cnt),
    .Mis_Cnt (mis_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_br = 0;
  int          exp_mis = 0;
  BResult      br_sb[$];
  logic [31:0] rd_sb[$];
  BResult      exp_b;
  logic [31:0] exp_pc;

  localparam PResult P_NONE = '0;

  task automatic clear_inputs();
    bus.EXE_Wr = 1'b0; bus.EXE_Valid = 1'b0; bus.EXE_Flush = 1'b0;
    bus.EXE_PC = '0; bus.EXE_BrOp = BR_NONE; bus.EXE_RsData = '0;
    bus.EXE_RtData = '0; bus.EXE_Imm16 = '0; bus.EXE_Instr26 = '0;
    bus.EXE_PResult = P_NONE; bus.ID_Valid = 1'b0;
  endtask

  task automatic drive_br(input BrOp_t op, input logic [31:0] pc, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm,
                          input logic [25:0] i26, input PResult p, input logic idv);
    bus.EXE_Wr = 1'b1; bus.EXE_Valid = 1'b1; bus.EXE_Flush = 1'b0;
    bus.EXE_PC = pc; bus.EXE_BrOp = op; bus.EXE_RsData = rs; bus.EXE_RtData = rt;
    bus.EXE_Imm16 = imm; bus.EXE_Instr26 = i26; bus.EXE_PResult = p; bus.ID_Valid = idv;
  endtask

  task automatic test_reset();
    clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.Redirect_Valid, bus.IF_Flush} !== 2'b00) begin n_bad++;
      $display("FAIL reset_redirect: got v=%b f=%b want 0 0", bus.Redirect_Valid, bus.IF_Flush); end
    n_cmp++; if (bus.Redirect_PC !== 32'h0) begin n_bad++;
      $display("FAIL reset_pc: got %h want 0", bus.Redirect_PC); end
    n_cmp++; if (bus.EXE_BResult !== BResult'(0)) begin n_bad++;
      $display("FAIL reset_bresult: got %h want 0", bus.EXE_BResult); end
    n_cmp++; if (br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin n_bad++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", br_cnt, mis_cnt); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_beq_mispredict();
    drive_br(BR_BEQ, 32'h1000, 32'd5, 32'd5, 16'h0004, 26'h0, P_NONE, 1'b1);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h1000, Target: 32'h1014, Type: BIsBran,
                             IsTaken: 1'b1, Hit: 1'b0, Count: NT});
    rd_sb.push_back(32'h1014); exp_br++; exp_mis++;
    @(negedge clk); clear_inputs();
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b) begin n_bad++;
      $display("FAIL beq_bresult: got %h want %h", bus.EXE_BResult, exp_b); end
    exp_pc = rd_sb.pop_front(); n_cmp++;
    if (bus.Redirect_Valid !== 1'b1 || bus.IF_Flush !== 1'b1 || bus.Redirect_PC !== exp_pc) begin n_bad++;
      $display("FAIL beq_redirect: got v=%b f=%b pc=%h want 1 1 %h", bus.Redirect_Valid, bus.IF_Flush, bus.Redirect_PC, exp_pc); end
    n_cmp++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin n_bad++;
      $display("FAIL beq_counters: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
    @(negedge clk);
    n_cmp++; if (bus.Redirect_Valid !== 1'b0 || bus.IF_Flush !== 1'b0 || bus.EXE_BResult.Valid !== 1'b0) begin n_bad++;
      $display("FAIL beq_one_cycle: got v=%b f=%b bv=%b want 0 0 0", bus.Redirect_Valid, bus.IF_Flush, bus.EXE_BResult.Valid); end
  endtask

  task automatic test_bne_not_taken();
    drive_br(BR_BNE, 32'h2000, 32'd7, 32'd7, 16'h0010, 26'h0,
             PResult'{Valid: 1'b1, Hit: 1'b1, Type: BIsBran, IsTaken: 1'b1, Target: 32'h2040, Count: WT}, 1'b1);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h2000, Target: 32'h2044, Type: BIsBran,
                             IsTaken: 1'b0, Hit: 1'b1, Count: WT});
    rd_sb.push_back(32'h2008); exp_br++; exp_mis++;
    @(negedge clk); clear_inputs();
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b) begin n_bad++;
      $display("FAIL bne_bresult: got %h want %h", bus.EXE_BResult, exp_b); end
    exp_pc = rd_sb.pop_front(); n_cmp++;
    if (bus.Redirect_Valid !== 1'b1 || bus.Redirect_PC !== exp_pc) begin n_bad++;
      $display("FAIL bne_redirect: got v=%b pc=%h want 1 %h", bus.Redirect_Valid, bus.Redirect_PC, exp_pc); end
    n_cmp++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin n_bad++;
      $display("FAIL bne_counters: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  task automatic test_jal_correct();
    drive_br(BR_JAL, 32'h3000, 32'h0, 32'h0, 16'h0, 26'h0000400,
             PResult'{Valid: 1'b1, Hit: 1'b1, Type: BIsCall, IsTaken: 1'b1, Target: 32'h1000, Count: T}, 1'b1);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h3000, Target: 32'h1000, Type: BIsCall,
                             IsTaken: 1'b1, Hit: 1'b1, Count: T});
    exp_br++;
    @(negedge clk); clear_inputs();
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b) begin n_bad++;
      $display("FAIL jal_bresult: got %h want %h", bus.EXE_BResult, exp_b); end
    n_cmp++; if (bus.Redirect_Valid !== 1'b0 || bus.IF_Flush !== 1'b0) begin n_bad++;
      $display("FAIL jal_no_redirect: got v=%b f=%b want 0 0", bus.Redirect_Valid, bus.IF_Flush); end
    n_cmp++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin n_bad++;
      $display("FAIL jal_counters: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  task automatic test_jr_wait_ds();
    drive_br(BR_JR, 32'h4000, 32'h8000_0010, 32'h0, 16'h0, 26'h0, P_NONE, 1'b0);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h4000, Target: 32'h8000_0010, Type: BIsRetn,
                             IsTaken: 1'b1, Hit: 1'b0, Count: NT});
    rd_sb.push_back(32'h8000_0010); exp_br++; exp_mis++;
    @(negedge clk); clear_inputs();
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b) begin n_bad++;
      $display("FAIL jr_bresult: got %h want %h", bus.EXE_BResult, exp_b); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.Redirect_Valid !== 1'b0 || bus.IF_Flush !== 1'b0) begin n_bad++;
        $display("FAIL jr_wait_%0d: got v=%b f=%b want 0 0", i, bus.Redirect_Valid, bus.IF_Flush); end
      if (i < 2) @(negedge clk);
    end
    bus.ID_Valid = 1'b1;
    @(negedge clk); bus.ID_Valid = 1'b0;
    exp_pc = rd_sb.pop_front(); n_cmp++;
    if (bus.Redirect_Valid !== 1'b1 || bus.IF_Flush !== 1'b1 || bus.Redirect_PC !== exp_pc) begin n_bad++;
      $display("FAIL jr_redirect: got v=%b f=%b pc=%h want 1 1 %h", bus.Redirect_Valid, bus.IF_Flush, bus.Redirect_PC, exp_pc); end
    // Back in IDLE: a later delay-slot cycle must not re-issue.
    bus.ID_Valid = 1'b1;
    @(negedge clk); bus.ID_Valid = 1'b0;
    n_cmp++; if (bus.Redirect_Valid !== 1'b0) begin n_bad++;
      $display("FAIL jr_single_redirect: got v=%b want 0", bus.Redirect_Valid); end
  endtask

  task automatic test_flush_in_wait();
    drive_br(BR_BLTZ, 32'h5000, 32'hFFFF_FFFF, 32'h0, 16'hFFFE, 26'h0, P_NONE, 1'b0);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h5000, Target: 32'h4FFC, Type: BIsBran,
                             IsTaken: 1'b1, Hit: 1'b0, Count: NT});
    exp_br++; exp_mis++;
    @(negedge clk); clear_inputs();
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b) begin n_bad++;
      $display("FAIL bltz_bresult: got %h want %h", bus.EXE_BResult, exp_b); end
    // Flush with the delay slot present and a branch in EXE: all dropped.
    drive_br(BR_BEQ, 32'h5100, 32'd1, 32'd1, 16'h0001, 26'h0, P_NONE, 1'b1);
    bus.EXE_Flush = 1'b1;
    @(negedge clk); clear_inputs(); bus.ID_Valid = 1'b1;
    n_cmp++; if (bus.Redirect_Valid !== 1'b0 || bus.EXE_BResult.Valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_cycle: got v=%b bv=%b want 0 0", bus.Redirect_Valid, bus.EXE_BResult.Valid); end
    n_cmp++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin n_bad++;
      $display("FAIL flush_counters: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.Redirect_Valid !== 1'b0 || bus.IF_Flush !== 1'b0) begin n_bad++;
        $display("FAIL flush_after_%0d: got v=%b f=%b want 0 0", i, bus.Redirect_Valid, bus.IF_Flush); end
    end
    bus.ID_Valid = 1'b0;
  endtask

  task automatic test_stall();
    drive_br(BR_BGTZ, 32'h6000, 32'd3, 32'h0, 16'h0008, 26'h0,
             PResult'{Valid: 1'b1, Hit: 1'b1, Type: BIsBran, IsTaken: 1'b1, Target: 32'h6024, Count: WT}, 1'b1);
    bus.EXE_Wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.EXE_BResult.Valid !== 1'b0 || br_cnt !== exp_br) begin n_bad++;
        $display("FAIL stall_%0d: got bv=%b cnt=%0d want 0 %0d", i, bus.EXE_BResult.Valid, br_cnt, exp_br); end
    end
    bus.EXE_Wr = 1'b1;
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h6000, Target: 32'h6024, Type: BIsBran,
                             IsTaken: 1'b1, Hit: 1'b1, Count: WT});
    exp_br++;
    @(negedge clk); bus.EXE_Wr = 1'b0;
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b || bus.Redirect_Valid !== 1'b0) begin n_bad++;
      $display("FAIL bgtz_bresult: got %h v=%b want %h 0", bus.EXE_BResult, bus.Redirect_Valid, exp_b); end
    @(negedge clk); clear_inputs();
    n_cmp++; if (bus.EXE_BResult.Valid !== 1'b0 || br_cnt !== exp_br || mis_cnt !== exp_mis) begin n_bad++;
      $display("FAIL stall_once: got bv=%b cnt=%0d/%0d want 0 %0d/%0d", bus.EXE_BResult.Valid, br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  task automatic test_back_to_back();
    drive_br(BR_BLEZ, 32'h7000, 32'h0, 32'h0, 16'h0001, 26'h0,
             PResult'{Valid: 1'b1, Hit: 1'b1, Type: BIsBran, IsTaken: 1'b1, Target: 32'h7008, Count: T}, 1'b1);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h7000, Target: 32'h7008, Type: BIsBran,
                             IsTaken: 1'b1, Hit: 1'b1, Count: T});
    exp_br++;
    @(negedge clk);
    drive_br(BR_BGEZAL, 32'h7004, 32'hFFFF_FFFB, 32'h0, 16'h0002, 26'h0, P_NONE, 1'b1);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h7004, Target: 32'h7010, Type: BIsCall,
                             IsTaken: 1'b0, Hit: 1'b0, Count: NT});
    exp_br++;
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b || bus.Redirect_Valid !== 1'b0) begin n_bad++;
      $display("FAIL blez_bresult: got %h v=%b want %h 0", bus.EXE_BResult, bus.Redirect_Valid, exp_b); end
    @(negedge clk); clear_inputs();
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b || bus.Redirect_Valid !== 1'b0) begin n_bad++;
      $display("FAIL bgezal_bresult: got %h v=%b want %h 0", bus.EXE_BResult, bus.Redirect_Valid, exp_b); end
    n_cmp++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin n_bad++;
      $display("FAIL b2b_counters: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  task automatic test_target_mismatch();
    drive_br(BR_BGEZ, 32'h8000, 32'h0, 32'h0, 16'h0003, 26'h0,
             PResult'{Valid: 1'b1, Hit: 1'b0, Type: BIsBran, IsTaken: 1'b1, Target: 32'h8020, Count: WT}, 1'b1);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h8000, Target: 32'h8010, Type: BIsBran,
                             IsTaken: 1'b1, Hit: 1'b0, Count: WT});
    rd_sb.push_back(32'h8010); exp_br++; exp_mis++;
    @(negedge clk);
    drive_br(BR_J, 32'h9000_0FFC, 32'h0, 32'h0, 16'h0, 26'h3FF_FFFF, P_NONE, 1'b1);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'h9000_0FFC, Target: 32'h9FFF_FFFC, Type: BIsJump,
                             IsTaken: 1'b1, Hit: 1'b0, Count: NT});
    rd_sb.push_back(32'h9FFF_FFFC); exp_br++; exp_mis++;
    for (int i = 0; i < 2; i++) begin
      exp_b = br_sb.pop_front(); exp_pc = rd_sb.pop_front(); n_cmp++;
      if (bus.EXE_BResult !== exp_b || bus.Redirect_Valid !== 1'b1 || bus.Redirect_PC !== exp_pc) begin n_bad++;
        $display("FAIL target_%0d: got %h v=%b pc=%h want %h 1 %h", i, bus.EXE_BResult, bus.Redirect_Valid, bus.Redirect_PC, exp_b, exp_pc); end
      if (i == 0) begin @(negedge clk); clear_inputs(); end
    end
    n_cmp++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin n_bad++;
      $display("FAIL target_counters: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    drive_br(BR_JR, 32'hA000, 32'h8000_0040, 32'h0, 16'h0, 26'h0, P_NONE, 1'b0);
    br_sb.push_back(BResult'{Valid: 1'b1, PC: 32'hA000, Target: 32'h8000_0040, Type: BIsRetn,
                             IsTaken: 1'b1, Hit: 1'b0, Count: NT});
    @(negedge clk); clear_inputs();
    exp_b = br_sb.pop_front(); n_cmp++;
    if (bus.EXE_BResult !== exp_b) begin n_bad++;
      $display("FAIL jr2_bresult: got %h want %h", bus.EXE_BResult, exp_b); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.EXE_BResult !== BResult'(0) || bus.Redirect_Valid !== 1'b0 || bus.IF_Flush !== 1'b0 ||
                 bus.Redirect_PC !== 32'h0 || br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin n_bad++;
      $display("FAIL async_reset: got br=%h v=%b pc=%h cnt=%0d/%0d want all 0", bus.EXE_BResult, bus.Redirect_Valid, bus.Redirect_PC, br_cnt, mis_cnt); end
    exp_br = 0; exp_mis = 0;
    @(negedge clk); rst = 1'b1; bus.ID_Valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.Redirect_Valid !== 1'b0) begin n_bad++;
        $display("FAIL reset_aborts_%0d: got v=%b want 0", i, bus.Redirect_Valid); end
    end
    bus.ID_Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bne_not_taken();
    test_jal_correct();
    test_jr_wait_ds();
    test_flush_in_wait();
    test_stall();
    test_back_to_back();
    test_target_mismatch();
    test_async_reset();
    n_cmp++; if (br_sb.size() != 0 || rd_sb.size() != 0) begin n_bad++;
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", br_sb.size(), rd_sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
